// File: rtl/seg_scan_driver.sv
// Six-digit common-anode 7-segment scanner with per-slot ghost gap and per-frame input snapshot.
// Optional macro LEADING_ZERO_BLANK_EN blanks digit 0 while its snapshot value is zero.
module seg_scan_driver #(
   parameter int CLK_HZ       = 50_000_000,
   parameter int SCAN_HZ      = 6_000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] hour_a,
   input  logic [5:0] hour_b,
   input  logic [5:0] min_a,
   input  logic [5:0] min_b,
   input  logic [5:0] sec_a,
   input  logic [5:0] sec_b,
   input  logic       colon,
   output logic [5:0] an,
   output logic [7:0] seg
);

   localparam int SLOT  = CLK_HZ / SCAN_HZ;
   localparam int CNT_W = (SLOT > 1) ? $clog2(SLOT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

   typedef enum logic {GAP, SHOW} slotState_t;

   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_idx;
   logic             r_loadPend;
   logic [5:0]       r_snap [6];

   logic [CNT_W-1:0] w_cntNext;
   logic [2:0]       w_idxNext;
   logic             w_lastCnt;
   logic             w_load;
   logic [5:0]       w_inDigits [6];
   logic [5:0]       w_snapNext [6];
   logic [5:0]       w_digit;
   slotState_t       w_slotNext;
   logic             w_dp;
   logic [6:0]       w_glyph;
   logic [5:0]       w_anNext;
   logic [7:0]       w_segNext;

   function automatic logic [6:0] encodeDigit(input logic [5:0] value);
      case (value)
         6'd0:    encodeDigit = 7'h40;
         6'd1:    encodeDigit = 7'h79;
         6'd2:    encodeDigit = 7'h24;
         6'd3:    encodeDigit = 7'h30;
         6'd4:    encodeDigit = 7'h19;
         6'd5:    encodeDigit = 7'h12;
         6'd6:    encodeDigit = 7'h02;
         6'd7:    encodeDigit = 7'h78;
         6'd8:    encodeDigit = 7'h00;
         6'd9:    encodeDigit = 7'h10;
         default: encodeDigit = 7'h3F;
      endcase
   endfunction

   assign w_inDigits[0] = hour_a;
   assign w_inDigits[1] = hour_b;
   assign w_inDigits[2] = min_a;
   assign w_inDigits[3] = min_b;
   assign w_inDigits[4] = sec_a;
   assign w_inDigits[5] = sec_b;

   // Outputs are computed from the next cnt/idx/snapshot so they move on the same edge.
   always_comb begin
      w_lastCnt  = (r_cnt == CNT_LAST);
      w_cntNext  = w_lastCnt ? '0 : r_cnt + 1'b1;
      w_idxNext  = r_idx;
      if (w_lastCnt) begin
         w_idxNext = (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
      end
      w_load = r_loadPend | (w_lastCnt & (r_idx == 3'd5));
      for (int i = 0; i < 6; i++) begin
         w_snapNext[i] = w_load ? w_inDigits[i] : r_snap[i];
      end
      w_digit    = w_snapNext[w_idxNext];
      w_slotNext = (w_cntNext < CNT_BLANK) ? GAP : SHOW;
      w_dp       = ((w_idxNext == 3'd1) || (w_idxNext == 3'd3)) ? ~colon : 1'b1;
      w_glyph    = encodeDigit(w_digit);
`ifdef LEADING_ZERO_BLANK_EN
      if ((w_idxNext == 3'd0) && (w_digit == 6'd0)) begin
         w_glyph = 7'h7F;
      end
`endif
      w_anNext  = 6'h3F;
      w_segNext = 8'hFF;
      if (w_slotNext == SHOW) begin
         w_anNext  = ~(6'b000001 << w_idxNext);
         w_segNext = {w_dp, w_glyph};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt      <= '0;
         r_idx      <= 3'd0;
         r_loadPend <= 1'b1;
         for (int i = 0; i < 6; i++) begin
            r_snap[i] <= 6'd0;
         end
         an  <= 6'h3F;
         seg <= 8'hFF;
      end else begin
         r_cnt      <= w_cntNext;
         r_idx      <= w_idxNext;
         r_loadPend <= 1'b0;
         for (int i = 0; i < 6; i++) begin
            r_snap[i] <= w_snapNext[i];
         end
         an  <= w_anNext;
         seg <= w_segNext;
      end
   end

endmodule
